// File: rtl/i2c_slave_responder.sv
// I2C target at a fixed 7-bit address. It decodes START/STOP and emits each received write byte.
// It fetches read bytes over a req/valid handshake and stretches SCL until each byte is supplied.
module i2c_slave_responder #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int                        SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o,
    output logic                      op_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      rd_nack_o
);

    localparam int NB = (I2C_DATA_WIDTH > I2C_ADDR_WIDTH + 1) ? I2C_DATA_WIDTH : I2C_ADDR_WIDTH + 1;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(I2C_ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(I2C_DATA_WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, RD_WAIT, READ, READ_ACKCHK, IGNORE
    } state_t;

    state_t                    state;
    logic [CW-1:0]             bit_cnt;
    logic                      phase_q;
    logic [NB-2:0]             shift_q;
    logic [I2C_DATA_WIDTH-2:0] rd_shift_q;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d, scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SCL must be high on both samples so a simultaneous SCL/SDA move is not taken as a bus condition.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // Read handshake: rd_req_o pulses once per byte. The first cycle in which rd_valid_i is high
    // while waiting consumes rd_data_i, and that can be the cycle of the pulse itself.
    // rd_valid_i is ignored at any other time.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            phase_q    <= 1'b0;
            shift_q    <= '0;
            rd_shift_q <= '0;
            scl_o      <= 1'b1;
            sda_o      <= 1'b1;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
            op_o       <= 1'b0;
            wr_data_o  <= '0;
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            rd_nack_o  <= 1'b0;
        end else begin
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            rd_nack_o  <= 1'b0;
            if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                phase_q <= 1'b0;
                scl_o   <= 1'b1;
                sda_o   <= 1'b1;
                busy_o  <= 1'b0;
                stop_o  <= 1'b1;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                phase_q <= 1'b0;
                scl_o   <= 1'b1;
                sda_o   <= 1'b1;
                busy_o  <= 1'b1;
                start_o <= 1'b1;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[NB-3:0], sda_s};
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == ADDR_LAST) begin
                                phase_q <= 1'b0;
                                if (shift_q[I2C_ADDR_WIDTH-1:0] == SLAVE_ADDR) begin
                                    op_o  <= sda_s;
                                    state <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK, WRITE_ACK: begin
                        // First fall starts driving ACK; the fall ending the 9th clock hands the bus back.
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_o   <= 1'b0;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                bit_cnt <= '0;
                                if (state == WRITE_ACK || !op_o) begin
                                    sda_o <= 1'b1;
                                    state <= WRITE;
                                end else begin
                                    scl_o    <= 1'b0;
                                    rd_req_o <= 1'b1;
                                    state    <= RD_WAIT;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[NB-3:0], sda_s};
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == DATA_LAST) begin
                                wr_data_o  <= {shift_q[I2C_DATA_WIDTH-2:0], sda_s};
                                wr_valid_o <= 1'b1;
                                phase_q    <= 1'b0;
                                state      <= WRITE_ACK;
                            end
                        end
                    end
                    RD_WAIT: begin
                        if (rd_valid_i) begin
                            rd_shift_q <= rd_data_i[I2C_DATA_WIDTH-2:0];
                            sda_o      <= rd_data_i[I2C_DATA_WIDTH-1];
                            scl_o      <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= READ;
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + CW'(1);
                            if (bit_cnt == DATA_LAST) begin
                                sda_o   <= 1'b1;
                                phase_q <= 1'b0;
                                state   <= READ_ACKCHK;
                            end else begin
                                sda_o      <= rd_shift_q[I2C_DATA_WIDTH-2];
                                rd_shift_q <= {rd_shift_q[I2C_DATA_WIDTH-3:0], 1'b1};
                            end
                        end
                    end
                    READ_ACKCHK: begin
                        if (scl_rise && !phase_q) begin
                            if (!sda_s) begin
                                phase_q <= 1'b1;
                            end else begin
                                rd_nack_o <= 1'b1;
                                state     <= IGNORE;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q  <= 1'b0;
                            bit_cnt  <= '0;
                            scl_o    <= 1'b0;
                            rd_req_o <= 1'b1;
                            state    <= RD_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder. A bit-level I2C master and a read-data responder drive the target.
// Expected bytes, ACKs and pulse counts are derived from the I2C transaction rules.
module tb_i2c_slave_responder;

    localparam int H = 10;

    logic       clk, rst_i, scl_m, sda_m;
    logic       scl_o, sda_o, start_o, stop_o, busy_o, op_o;
    logic       wr_valid_o, rd_req_o, rd_valid_i, rd_nack_o;
    logic [7:0] wr_data_o, rd_data_i;
    logic       scl_bus, sda_bus;

    assign scl_bus = scl_m & scl_o;
    assign sda_bus = sda_m & sda_o;

    int n_checks = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int wr_cnt = 0;
    int rd_req_cnt = 0;
    int nack_cnt = 0;
    int scl_low_cnt = 0;
    int rd_idx = 0;
    int rd_delay = 0;
    logic [7:0] wr_log [0:255];
    logic [7:0] rd_tab [0:255];
    logic [7:0] exp_q[$];

    i2c_slave_responder dut (
        .clk_i(clk), .rst_i(rst_i), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_o(scl_o), .sda_o(sda_o), .start_o(start_o), .stop_o(stop_o),
        .busy_o(busy_o), .op_o(op_o), .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
        .rd_req_o(rd_req_o), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
        .rd_nack_o(rd_nack_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // monitor
    always @(negedge clk) begin
        if (!rst_i) begin
            if (start_o)   start_cnt  <= start_cnt + 1;
            if (stop_o)    stop_cnt   <= stop_cnt + 1;
            if (rd_req_o)  rd_req_cnt <= rd_req_cnt + 1;
            if (rd_nack_o) nack_cnt   <= nack_cnt + 1;
            if (scl_o === 1'b0) scl_low_cnt <= scl_low_cnt + 1;
            if (wr_valid_o) begin
                wr_log[wr_cnt % 256] <= wr_data_o;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    // read-data responder: answers each rd_req_o after rd_delay cycles
    initial begin
        rd_valid_i = 1'b0;
        rd_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_req_o === 1'b1) begin
                repeat (rd_delay) @(negedge clk);
                rd_data_i  = rd_tab[rd_idx % 256];
                rd_valid_i = 1'b1;
                rd_idx     = rd_idx + 1;
                @(negedge clk);
                rd_valid_i = 1'b0;
                rd_data_i  = 8'h00;
            end
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (scl_bus !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (scl_bus !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL scl_release: scl low after %0d cycles, required high", n);
        end
    endtask

    task automatic bus_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1;
            wait_cyc(H);
            scl_m = 1'b1;
            wait_scl_high();
        end
        sda_m = 1'b1;
        wait_cyc(H);
        sda_m = 1'b0;
        wait_cyc(H);
        scl_m = 1'b0;
        wait_cyc(H);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_cyc(H);
        scl_m = 1'b1;
        wait_scl_high();
        wait_cyc(H);
        sda_m = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        wait_cyc(H);
        scl_m = 1'b1;
        wait_scl_high();
        wait_cyc(H);
        scl_m = 1'b0;
        wait_cyc(H);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_cyc(H);
        scl_m = 1'b1;
        wait_scl_high();
        wait_cyc(H / 2);
        b = sda_bus;
        wait_cyc(H / 2);
        scl_m = 1'b0;
        wait_cyc(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic bit_v;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(bit_v);
            b = {b[6:0], bit_v};
        end
        send_bit(nack);
    endtask

    // scenarios
    task automatic test_reset();
        rst_i = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_cyc(5);
        n_checks++; if (scl_o !== 1'b1) begin n_fail++; $display("FAIL rst_scl: got %b want 1", scl_o); end
        n_checks++; if (sda_o !== 1'b1) begin n_fail++; $display("FAIL rst_sda: got %b want 1", sda_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_checks++; if (op_o !== 1'b0) begin n_fail++; $display("FAIL rst_op: got %b want 0", op_o); end
        n_checks++; if (wr_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data: got %h want 00", wr_data_o); end
        n_checks++;
        if ({start_o, stop_o, wr_valid_o, rd_req_o, rd_nack_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_pulses: got %b want 00000", {start_o, stop_o, wr_valid_o, rd_req_o, rd_nack_o});
        end
        rst_i = 1'b0;
        wait_cyc(10);
        n_checks++; if (busy_o !== 1'b0 || start_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst: busy %b start %b want 0 0", busy_o, start_o); end
    endtask

    task automatic test_write_burst();
        logic ack;
        logic [7:0] exp_b;
        int wr_base, st_base, sp_base;
        wr_base = wr_cnt; st_base = start_cnt; sp_base = stop_cnt;
        bus_start();
        write_byte(8'h44, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wb_addr_ack: got %b want 0", ack); end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(8'(i));
            write_byte(8'(i), ack);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wb_data_ack[%0d]: got %b want 0", i, ack); end
        end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wb_busy: got %b want 1", busy_o); end
        bus_stop();
        wait_cyc(4);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wb_busy_end: got %b want 0", busy_o); end
        n_checks++; if (start_cnt - st_base != 1) begin n_fail++; $display("FAIL wb_starts: got %0d want 1", start_cnt - st_base); end
        n_checks++; if (stop_cnt - sp_base != 1) begin n_fail++; $display("FAIL wb_stops: got %0d want 1", stop_cnt - sp_base); end
        n_checks++; if (wr_cnt - wr_base != exp_q.size()) begin n_fail++; $display("FAIL wb_count: got %0d want %0d", wr_cnt - wr_base, exp_q.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (wr_log[(wr_base + k) % 256] !== exp_b) begin
                n_fail++;
                $display("FAIL wb_data[%0d]: got %h want %h", k, wr_log[(wr_base + k) % 256], exp_b);
            end
        end
    endtask

    task automatic test_read_burst();
        logic ack;
        logic [7:0] d;
        int req_base, nk_base, sp_base;
        req_base = rd_req_cnt; nk_base = nack_cnt; sp_base = stop_cnt;
        rd_delay = 0;
        for (int i = 0; i < 32; i++) rd_tab[(rd_idx + i) % 256] = 8'(100 + i);
        bus_start();
        write_byte(8'h45, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rb_addr_ack: got %b want 0", ack); end
        n_checks++; if (op_o !== 1'b1) begin n_fail++; $display("FAIL rb_op: got %b want 1", op_o); end
        for (int i = 0; i < 32; i++) begin
            read_byte(i == 31, d);
            n_checks++; if (d !== 8'(100 + i)) begin n_fail++; $display("FAIL rb_data[%0d]: got %0d want %0d", i, d, 100 + i); end
        end
        wait_cyc(4);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rb_busy_ignore: got %b want 1", busy_o); end
        n_checks++; if (rd_req_cnt - req_base != 32) begin n_fail++; $display("FAIL rb_reqs: got %0d want 32", rd_req_cnt - req_base); end
        n_checks++; if (nack_cnt - nk_base != 1) begin n_fail++; $display("FAIL rb_nack: got %0d want 1", nack_cnt - nk_base); end
        bus_stop();
        wait_cyc(4);
        n_checks++; if (stop_cnt - sp_base != 1) begin n_fail++; $display("FAIL rb_stops: got %0d want 1", stop_cnt - sp_base); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rb_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int wr_base;
        wr_base = wr_cnt;
        bus_start();
        write_byte(8'h60, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wa_addr_ack: got %b want 1", ack); end
        write_byte(8'hA5, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wa_data_ack: got %b want 1", ack); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wa_busy: got %b want 1", busy_o); end
        bus_stop();
        wait_cyc(4);
        n_checks++; if (wr_cnt != wr_base) begin n_fail++; $display("FAIL wa_no_write: got %0d want 0", wr_cnt - wr_base); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wa_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_stretch();
        logic ack;
        logic [7:0] d, exp_b;
        int low_base;
        exp_b = 8'($urandom_range(0, 255));
        rd_tab[rd_idx % 256] = exp_b;
        rd_delay = 50;
        low_base = scl_low_cnt;
        bus_start();
        write_byte(8'h45, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL st_addr_ack: got %b want 0", ack); end
        read_byte(1'b1, d);
        n_checks++; if (d !== exp_b) begin n_fail++; $display("FAIL st_data: got %h want %h", d, exp_b); end
        n_checks++; if (scl_low_cnt - low_base < 50) begin n_fail++; $display("FAIL st_stretch: got %0d cycles want >=50", scl_low_cnt - low_base); end
        bus_stop();
        rd_delay = 0;
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] d, exp_b;
        int st_base, wr_base;
        st_base = start_cnt; wr_base = wr_cnt;
        rd_tab[rd_idx % 256] = 8'h3F;
        bus_start();
        write_byte(8'h44, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_waddr_ack: got %b want 0", ack); end
        n_checks++; if (op_o !== 1'b0) begin n_fail++; $display("FAIL rs_op_w: got %b want 0", op_o); end
        exp_q.push_back(8'h40);
        write_byte(8'h40, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_data_ack: got %b want 0", ack); end
        bus_start();
        write_byte(8'h45, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_raddr_ack: got %b want 0", ack); end
        n_checks++; if (op_o !== 1'b1) begin n_fail++; $display("FAIL rs_op_r: got %b want 1", op_o); end
        read_byte(1'b1, d);
        n_checks++; if (d !== 8'h3F) begin n_fail++; $display("FAIL rs_rdata: got %h want 3f", d); end
        bus_stop();
        wait_cyc(4);
        n_checks++; if (start_cnt - st_base != 2) begin n_fail++; $display("FAIL rs_starts: got %0d want 2", start_cnt - st_base); end
        n_checks++; if (wr_cnt - wr_base != exp_q.size()) begin n_fail++; $display("FAIL rs_count: got %0d want %0d", wr_cnt - wr_base, exp_q.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (wr_log[(wr_base + k) % 256] !== exp_b) begin n_fail++; $display("FAIL rs_wdata[%0d]: got %h want %h", k, wr_log[(wr_base + k) % 256], exp_b); end
        end
    endtask

    task automatic test_reset_mid_ack();
        logic ack;
        logic [7:0] ab, exp_b;
        int wr_base;
        ab = 8'h44;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(ab[i]);
        n_checks++; if (sda_o !== 1'b0) begin n_fail++; $display("FAIL ma_ack_drive: got %b want 0", sda_o); end
        #3;
        rst_i = 1'b1;
        #1;
        n_checks++; if (sda_o !== 1'b1) begin n_fail++; $display("FAIL ma_async_sda: got %b want 1", sda_o); end
        n_checks++; if (scl_o !== 1'b1) begin n_fail++; $display("FAIL ma_async_scl: got %b want 1", scl_o); end
        wait_cyc(2);
        n_checks++; if (busy_o !== 1'b0 || wr_data_o !== 8'h00) begin n_fail++; $display("FAIL ma_rst_state: busy %b data %h want 0 00", busy_o, wr_data_o); end
        scl_m = 1'b1;
        wait_cyc(3);
        sda_m = 1'b1;
        wait_cyc(3);
        rst_i = 1'b0;
        wait_cyc(5);
        wr_base = wr_cnt;
        bus_start();
        write_byte(8'h44, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ma_addr_ack: got %b want 0", ack); end
        exp_q.push_back(8'h5A);
        write_byte(8'h5A, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ma_data_ack: got %b want 0", ack); end
        bus_stop();
        wait_cyc(4);
        n_checks++; if (wr_cnt - wr_base != exp_q.size()) begin n_fail++; $display("FAIL ma_count: got %0d want %0d", wr_cnt - wr_base, exp_q.size()); end
        for (int k = 0; exp_q.size() > 0; k++) begin
            exp_b = exp_q.pop_front();
            n_checks++;
            if (wr_log[(wr_base + k) % 256] !== exp_b) begin n_fail++; $display("FAIL ma_wdata[%0d]: got %h want %h", k, wr_log[(wr_base + k) % 256], exp_b); end
        end
    endtask

    task automatic test_random();
        logic ack, match, rw, exp_ack;
        logic [6:0] a7;
        logic [7:0] b, d, exp_b;
        int n, wr_base, req_base;
        for (int t = 0; t < 6; t++) begin
            match = 1'($urandom_range(0, 1));
            rw    = 1'($urandom_range(0, 1));
            a7    = match ? 7'h22 : 7'($urandom_range(0, 127));
            if (!match && a7 == 7'h22) a7 = 7'h23;
            exp_ack = match ? 1'b0 : 1'b1;
            n = $urandom_range(1, 4);
            rd_delay = $urandom_range(0, 6);
            wr_base = wr_cnt; req_base = rd_req_cnt;
            bus_start();
            write_byte({a7, rw}, ack);
            n_checks++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rnd_addr_ack[%0d]: got %b want %b", t, ack, exp_ack); end
            if (match) begin
                n_checks++; if (op_o !== rw) begin n_fail++; $display("FAIL rnd_op[%0d]: got %b want %b", t, op_o, rw); end
            end
            if (!rw) begin
                for (int k = 0; k < n; k++) begin
                    b = 8'($urandom_range(0, 255));
                    if (match) exp_q.push_back(b);
                    write_byte(b, ack);
                    n_checks++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rnd_wack[%0d.%0d]: got %b want %b", t, k, ack, exp_ack); end
                end
            end else if (match) begin
                for (int k = 0; k < n; k++) rd_tab[(rd_idx + k) % 256] = 8'($urandom_range(0, 255));
                for (int k = 0; k < n; k++) begin
                    exp_b = rd_tab[(req_base - rd_req_cnt + rd_idx + k) % 256];
                    read_byte(k == n - 1, d);
                    n_checks++; if (d !== exp_b) begin n_fail++; $display("FAIL rnd_rdata[%0d.%0d]: got %h want %h", t, k, d, exp_b); end
                end
                n_checks++; if (rd_req_cnt - req_base != n) begin n_fail++; $display("FAIL rnd_reqs[%0d]: got %0d want %0d", t, rd_req_cnt - req_base, n); end
            end
            bus_stop();
            wait_cyc(4);
            n_checks++; if (wr_cnt - wr_base != exp_q.size()) begin n_fail++; $display("FAIL rnd_wcount[%0d]: got %0d want %0d", t, wr_cnt - wr_base, exp_q.size()); end
            for (int k = 0; exp_q.size() > 0; k++) begin
                exp_b = exp_q.pop_front();
                n_checks++;
                if (wr_log[(wr_base + k) % 256] !== exp_b) begin n_fail++; $display("FAIL rnd_wdata[%0d.%0d]: got %h want %h", t, k, wr_log[(wr_base + k) % 256], exp_b); end
            end
        end
        rd_delay = 0;
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrong_addr();
        test_stretch();
        test_repeated_start();
        test_reset_mid_ack();
        test_random();
        wait_cyc(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (responder) for the far end of the I2C bus driven by the iicmb master controller.
- Decodes START, STOP and a 7-bit address, accepts write bytes and supplies read bytes through handshake ports.
- Stretches SCL while waiting for read data.
- Replaces the behavioural I2C slave BFM for gate-level and FPGA checks of the controller.

Parameters:
- I2C_ADDR_WIDTH, 7, address width; only 7 is supported.
- I2C_DATA_WIDTH, 8, data byte width.
- SLAVE_ADDR, 7'h22, address this target responds to.
- SYNC_STAGES, 2, flops in the scl_i/sda_i synchronizers (≥2).

Ports:
- clk_i  in  1  system clock; ≥8× SCL frequency.
- rst_i  in  1  reset.
- scl_i  in  1  bus SCL sampled.
- sda_i  in  1  bus SDA sampled.
- scl_o  out  1  SCL drive; 0 = pull low, 1 = release.
- sda_o  out  1  SDA drive; 0 = pull low, 1 = release.
- start_o  out  1  one-cycle pulse on START or repeated START.
- stop_o  out  1  one-cycle pulse on STOP.
- busy_o  out  1  high from START to STOP.
- op_o  out  1  R/W bit of the current addressed transfer; 0 = write, 1 = read.
- wr_data_o  out  I2C_DATA_WIDTH  last received write byte.
- wr_valid_o  out  1  one-cycle pulse; wr_data_o is valid.
- rd_req_o  out  1  one-cycle pulse requesting the next read byte.
- rd_data_i  in  I2C_DATA_WIDTH  read byte.
- rd_valid_i  in  1  rd_data_i valid; consumed in the cycle it is sampled high after rd_req_o.
- rd_nack_o  out  1  one-cycle pulse when the master NACKs a read byte.

Interface decision: one clock (clk_i); rst_i is asynchronous, active-high.

Behaviour:
- Reset, asynchronous:
  - scl_o = 1, sda_o = 1.
  - All pulses = 0, busy_o = 0, op_o = 0, wr_data_o = 0.
  - FSM = IDLE, bit counter = 0.
  - Reset mid-transfer releases both lines immediately.
- Synchronization: scl_i and sda_i pass through SYNC_STAGES flops, plus one history flop for edge detection. All events below are referenced to synchronized edges.
- Bus events:
  - START = sda falls while scl high.
  - STOP = sda rises while scl high.
  - start_o/stop_o pulse SYNC_STAGES+1 cycles after the pin edge.
  - Data is sampled on scl rise; sda_o changes only on scl fall.
- Priority:
  - STOP in any state: → IDLE, release lines, busy_o = 0.
  - START in any state: → ADDR, bit counter = 0, busy_o = 1, release lines.
  - STOP and START take priority over bit processing in the same cycle.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, RD_WAIT, READ, READ_ACKCHK, IGNORE.
- ADDR:
  - Shift 8 bits MSB-first.
  - On the 8th scl rise: if bits[7:1] == SLAVE_ADDR, latch op_o = bit0 and go to ADDR_ACK; else go to IGNORE.
- ADDR_ACK:
  - On the next scl fall, sda_o = 0; held through the 9th clock until its scl fall.
  - At that fall: op_o = 0 → WRITE (sda_o = 1); op_o = 1 → RD_WAIT.
- WRITE:
  - Shift 8 bits.
  - On the 8th scl rise: wr_data_o updates and wr_valid_o pulses the following cycle; → WRITE_ACK.
- WRITE_ACK: always ACK (drive 0 as in ADDR_ACK), then → WRITE.
- RD_WAIT:
  - rd_req_o pulses on entry.
  - scl_o = 0 until rd_valid_i is sampled 1 (the same cycle is allowed).
  - On that cycle: latch rd_data_i, set sda_o = data MSB; scl_o releases the next cycle; → READ.
- READ:
  - Bit counter advances on each scl fall; sda_o = next bit.
  - After the 8th bit's scl fall, sda_o = 1 (release) → READ_ACKCHK.
- READ_ACKCHK: on the 9th scl rise sample sda.
  - 0 (ACK) → RD_WAIT at the following scl fall.
  - 1 (NACK) → rd_nack_o pulse → IGNORE.
- IGNORE: lines released; waits only for START/STOP.
- Bit counter: 0..8 per byte, clears on entering any byte state. No wrap beyond 9 clocks.
- A START during RD_WAIT cancels the stretch (scl_o = 1) and drops the pending request; any later rd_valid_i is ignored.
- rd_valid_i outside RD_WAIT is ignored.

Test Plan:
- Write 0x44 (addr 0x22, W), bytes 0x00..0x1F, STOP → 32 wr_valid_o pulses with data 0x00..0x1F in order; ACK on all 33 bytes; start_o = 1 pulse; stop_o = 1 pulse.
- Read from 0x45 (addr 0x22, R), 32 bytes with rd_data_i = 100+i, master ACKs 31 then NACKs → master receives 100..131; 32 rd_req_o pulses; rd_nack_o pulse; IGNORE until STOP.
- Address 0x30 write → no ACK (SDA high on 9th clock); no wr_valid_o; busy_o = 1 until STOP.
- Read with rd_valid_i delayed 50 cycles after rd_req_o → scl_o = 0 for ≥50 cycles; byte correct afterwards.
- Write 1 byte 0x40, repeated START, read 1 byte 0x3F → start_o pulses twice; op_o changes 0 → 1; data correct.
- Assert rst_i mid-ACK → sda_o = 1, scl_o = 1 asynchronously; next START addressed transfer succeeds.
